fifo_dp_push_arbiter: RTL and testbench
=======================================

// Module: fifo_dp_push_arbiter
// PURPOSE
//  Shares the two push ports of a dual-ported FIFO among NREQ valid/ready requesters.
//  Grants up to two requesters per cycle in round-robin order.
//  Enforces the FIFO rules: slot 1 before slot 2, and push_2 only together with push_1.
//  Blocks all grants for a programmable window after a pipeline flush.
// PARAMETERS
//  NREQ        4   number of requesters (>=2)
//  DW          16  data width per entry
//  FLUSH_HOLD  2   cycles grants stay blocked after the valid_flush cycle (0..15)
//  STARVE_LIM  8   wait cycles before a requester is boosted (STARVE_BOOST_EN only, >=1)
// PORTS
//  clk          in   1          clock
//  rst          in   1          reset, asynchronous, active-high
//  valid_flush  in   1          pipeline flush
//  req_valid    in   NREQ       requester i holds valid data
//  req_data     in   NREQ*DW    packed [NREQ-1:0][DW-1:0] requester payloads
//  req_ready    out  NREQ       requester i granted (transfer = valid&ready)
//  ready_1      in   1          FIFO has space for >=1 entry
//  ready_2      in   1          FIFO has space for >=2 entries
//  push_1       out  1          FIFO push slot 1
//  push_data_1  out  DW         slot-1 payload
//  push_2       out  1          FIFO push slot 2
//  push_data_2  out  DW         slot-2 payload
//  hold         out  1          arbiter is in HOLD state
// BEHAVIOUR
//  - Grant path is combinational (0-cycle latency). State updates on the posedge.
//  - Reset: state=RUN, rr_ptr=0, hold counter=0, wait counters=0.
//  - While rst is high, req_ready, push_1 and push_2 are forced to 0. Data outputs are 0 when the matching push is 0.
//  - FSM RUN: grants allowed.
//  - FSM HOLD: no grants. hold=1. Counter decrements each cycle; at 0 the FSM returns to RUN.
//  - valid_flush in any state: grants are blocked in that same cycle. Next state is HOLD with counter=FLUSH_HOLD.
//    With FLUSH_HOLD=0 the next state is RUN. A flush during HOLD reloads the counter.
//  - Grant rules in RUN:
//    - ready_1=0: no grants.
//    - Slot 1 goes to the first valid requester scanning from rr_ptr upward, with wrap-around.
//    - Slot 2 goes to the next distinct valid requester, and only if ready_2=1.
//    - At most one grant per requester per cycle.
//    - push_2=1 implies push_1=1.
//  - rr_ptr update: on any grant, rr_ptr = (index of last granted requester + 1) mod NREQ. Unchanged with no grant.
//  - Requesters hold valid and data stable until granted. The arbiter does not buffer payloads.
// CONFIGURATION
//  STARVE_BOOST_EN defined:
//    - Each requester has a wait counter saturating at STARVE_LIM.
//    - The counter increments when valid, not granted and state=RUN. It clears on grant or when valid=0.
//    - Any requester at the limit takes slot 1: the lowest-index starving one, overriding rr order.
//    - Slot 2 then follows normal rr scanning, skipping the slot-1 winner.
//    - rr_ptr update uses the last granted index as above.
//  STARVE_BOOST_EN undefined: pure round-robin. Wait counters are not instantiated.
// STRUCTURE
//  - Package dp_arb_pkg:
//    - arb_state_t enum {RUN, HOLD}
//    - PTR_W = $clog2(NREQ) helper
//    - hold-counter width constant (4 bits)
//  - Sub-module rr_pick_two:
//    - inputs: request vector and start pointer
//    - outputs: first/second one-hot picks and their found flags
//    - rotate, priority-find twice, unrotate
//  - Payload muxes use one-hot AND-OR selection from req_data.
// TESTING
//  - Reset mid-traffic: rst=1 while req_valid=4'b1111 -> push_1=push_2=0 and req_ready=0 immediately. rr_ptr=0 after release.
//  - Round-robin rotation, ready_1=ready_2=1, req_valid=4'b1111 for 3 cycles:
//    - cycle 1 grants {0,1}, cycle 2 grants {2,3}, cycle 3 grants {0,1}.
//    - push_data_1/push_data_2 carry req_data[0]/req_data[1] respectively in cycle 1.
//  - Single slot, ready_1=1, ready_2=0, req_valid=4'b0110, rr_ptr=0:
//    - only requester 1 is granted on slot 1. push_2=0.
//    - next cycle requester 2 is granted.
//  - FIFO full, ready_1=0, req_valid=4'b1111: no grants, rr_ptr unchanged.
//  - Flush with FLUSH_HOLD=2, valid_flush at cycle t:
//    - no grants at t, t+1 and t+2. hold=1 at t+1 and t+2.
//    - grants resume at t+3.
//    - a second flush at t+1 extends blocking through t+3.
//  - Starvation boost (STARVE_BOOST_EN, STARVE_LIM=2):
//    - force requester 3 to lose for 2 cycles.
//    - next RUN cycle with ready_1=1: requester 3 is granted on slot 1 regardless of rr_ptr.

Source files
------------

// File: rtl/dp_arb_pkg.sv
// Shared types and sizing helpers for the dual-port FIFO push arbiter.
package dp_arb_pkg;

  typedef enum logic [0:0] {
    RUN,
    HOLD
  } arb_state_t;

  localparam int unsigned HOLD_CNT_W = 4;

  // Pointer width, never below one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_dp_push_arbiter_if.sv
// Requester/FIFO side signals of the dual-port push arbiter.
interface fifo_dp_push_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16
);
  logic                     valid_flush;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic [NREQ-1:0]          req_ready;
  logic                     ready_1;
  logic                     ready_2;
  logic                     push_1;
  logic [DW-1:0]            push_data_1;
  logic                     push_2;
  logic [DW-1:0]            push_data_2;
  logic                     hold;

  // Arbiter side.
  modport master (
    input  valid_flush, req_valid, req_data, ready_1, ready_2,
    output req_ready, push_1, push_data_1, push_2, push_data_2, hold
  );

  // Requesters plus FIFO side.
  modport slave (
    output valid_flush, req_valid, req_data, ready_1, ready_2,
    input  req_ready, push_1, push_data_1, push_2, push_data_2, hold
  );
endinterface

// File: rtl/fifo_dp_push_arbiter_rr_pick_two.sv
// Finds the first two set request bits scanning upward from a start index, with wrap-around.
module rr_pick_two #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [PTR_W-1:0] i_start,
  output logic [NREQ-1:0]  o_first_oh,
  output logic [NREQ-1:0]  o_second_oh,
  output logic             o_first_found,
  output logic             o_second_found
);

  logic [NREQ-1:0]  w_rot;
  logic [NREQ-1:0]  w_rot_first;
  logic [NREQ-1:0]  w_rot_second;
  logic [PTR_W-1:0] w_rot_idx;
  logic [PTR_W-1:0] w_unrot_idx;

  // Rotated bit k is original requester (k + start) mod NREQ.
  always_comb begin
    w_rot     = '0;
    w_rot_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_rot_idx = PTR_W'((k + int'(i_start)) % NREQ);
      w_rot[k]  = i_req[w_rot_idx];
    end
  end

  always_comb begin
    w_rot_first    = '0;
    w_rot_second   = '0;
    o_first_found  = 1'b0;
    o_second_found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_rot[k]) begin
        if (!o_first_found) begin
          w_rot_first[k] = 1'b1;
          o_first_found  = 1'b1;
        end else if (!o_second_found) begin
          w_rot_second[k] = 1'b1;
          o_second_found  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    o_first_oh  = '0;
    o_second_oh = '0;
    w_unrot_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_unrot_idx              = PTR_W'((k + int'(i_start)) % NREQ);
      o_first_oh[w_unrot_idx]  = w_rot_first[k];
      o_second_oh[w_unrot_idx] = w_rot_second[k];
    end
  end

endmodule

// File: rtl/fifo_dp_push_arbiter.sv
// Round-robin arbiter sharing the two push ports of a dual-ported FIFO among NREQ requesters.
// Optional starvation boost is enabled by defining STARVE_BOOST_EN.
module fifo_dp_push_arbiter
  import dp_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DW         = 16,
  parameter int unsigned FLUSH_HOLD = 2,
  parameter int unsigned STARVE_LIM = 8
) (
  input logic                    clk,
  input logic                    rst,
  fifo_dp_push_arbiter_if.master bus
);

  localparam int unsigned PTR_W = ptr_w(NREQ);

  if (NREQ < 2 || FLUSH_HOLD > 15 || STARVE_LIM < 1) begin : g_param_check
    $error("fifo_dp_push_arbiter: parameter out of range");
  end

  arb_state_t            r_state, w_state_nxt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt, w_last_idx;

  logic            w_grant_en, w_push_1, w_push_2;
  logic [NREQ-1:0] w_pick_req, w_first_oh, w_second_oh, w_slot1_oh, w_slot2_oh;
  logic [NREQ-1:0] w_grant_1, w_grant_2, w_last_oh;
  logic            w_first_found, w_second_found, w_found_1, w_found_2;
  logic [NREQ-1:0] w_starve_oh;
  logic            w_starve;

  assign w_grant_en = !rst && (r_state == RUN) && !bus.valid_flush && bus.ready_1;

`ifdef STARVE_BOOST_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_LIM + 1);
  logic [NREQ-1:0][WAIT_W-1:0] r_wait;

  // Lowest-index valid requester whose wait counter has saturated.
  always_comb begin
    w_starve_oh = '0;
    w_starve    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_starve && bus.req_valid[i] && (r_wait[i] == WAIT_W'(STARVE_LIM))) begin
        w_starve_oh[i] = 1'b1;
        w_starve       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] || bus.req_ready[i]) begin
          r_wait[i] <= '0;
        end else if ((r_state == RUN) && (r_wait[i] != WAIT_W'(STARVE_LIM))) begin
          r_wait[i] <= r_wait[i] + WAIT_W'(1);
        end
      end
    end
  end
`else
  assign w_starve_oh = '0;
  assign w_starve    = 1'b0;
`endif

  // A boosted requester owns slot 1; the picker then supplies slot 2 from rr order.
  assign w_pick_req = bus.req_valid & ~w_starve_oh;

  rr_pick_two #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .i_req          (w_pick_req),
    .i_start        (r_rr_ptr),
    .o_first_oh     (w_first_oh),
    .o_second_oh    (w_second_oh),
    .o_first_found  (w_first_found),
    .o_second_found (w_second_found)
  );

  assign w_slot1_oh = w_starve ? w_starve_oh : w_first_oh;
  assign w_found_1  = w_starve | w_first_found;
  assign w_slot2_oh = w_starve ? w_first_oh : w_second_oh;
  assign w_found_2  = w_starve ? w_first_found : w_second_found;

  assign w_push_1  = w_grant_en && w_found_1;
  assign w_push_2  = w_push_1 && bus.ready_2 && w_found_2;
  assign w_grant_1 = w_push_1 ? w_slot1_oh : '0;
  assign w_grant_2 = w_push_2 ? w_slot2_oh : '0;
  assign w_last_oh = w_push_2 ? w_grant_2 : w_grant_1;

  assign bus.req_ready = w_grant_1 | w_grant_2;
  assign bus.push_1    = w_push_1;
  assign bus.push_2    = w_push_2;
  assign bus.hold      = (r_state == HOLD);

  always_comb begin
    bus.push_data_1 = '0;
    bus.push_data_2 = '0;
    w_last_idx      = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.push_data_1 = bus.push_data_1 | (bus.req_data[i] & {DW{w_grant_1[i]}});
      bus.push_data_2 = bus.push_data_2 | (bus.req_data[i] & {DW{w_grant_2[i]}});
      if (w_last_oh[i]) w_last_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_push_1) begin
      w_rr_ptr_nxt = (w_last_idx == PTR_W'(NREQ - 1)) ? '0 : w_last_idx + PTR_W'(1);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    if (bus.valid_flush) begin
      w_hold_cnt_nxt = HOLD_CNT_W'(FLUSH_HOLD);
      w_state_nxt    = (FLUSH_HOLD == 0) ? RUN : HOLD;
    end else if (r_state == HOLD) begin
      w_hold_cnt_nxt = r_hold_cnt - HOLD_CNT_W'(1);
      if (w_hold_cnt_nxt == '0) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_hold_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_dp_push_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_fifo_dp_push_arbiter;

  localparam int unsigned NREQ       = 4;
  localparam int unsigned DW         = 16;
  localparam int unsigned FLUSH_HOLD = 2;
`ifdef STARVE_BOOST_EN
  localparam int unsigned STARVE_LIM = 2;
`else
  localparam int unsigned STARVE_LIM = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_dp_push_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  fifo_dp_push_arbiter #(
    .NREQ       (NREQ),
    .DW         (DW),
    .FLUSH_HOLD (FLUSH_HOLD),
    .STARVE_LIM (STARVE_LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: pointer, remaining blocked cycles, per-requester wait cycles.
  int m_ptr;
  int m_hold_left;
  int m_wait [NREQ];

  int              e_s1, e_s2;
  logic [NREQ-1:0] e_ready;
  logic [DW-1:0]   e_d1, e_d2;

  logic [NREQ-1:0] last_ready;
  logic [DW-1:0]   last_d1, last_d2;
  logic            last_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ptr       = 0;
    m_hold_left = 0;
    for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
  endfunction

  function automatic void model_eval();
    int idx;
    e_s1 = -1;
    e_s2 = -1;
    if (m_hold_left == 0 && !bus.valid_flush && bus.ready_1) begin
`ifdef STARVE_BOOST_EN
      for (int i = 0; i < NREQ; i++)
        if (e_s1 < 0 && bus.req_valid[i] && m_wait[i] >= STARVE_LIM) e_s1 = i;
`endif
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (bus.req_valid[idx] && idx != e_s1) begin
          if (e_s1 < 0) e_s1 = idx;
          else if (e_s2 < 0 && bus.ready_2) e_s2 = idx;
        end
      end
    end
    e_ready = '0;
    e_d1    = '0;
    e_d2    = '0;
    if (e_s1 >= 0) begin
      e_ready[e_s1] = 1'b1;
      e_d1 = bus.req_data[e_s1];
    end
    if (e_s2 >= 0) begin
      e_ready[e_s2] = 1'b1;
      e_d2 = bus.req_data[e_s2];
    end
  endfunction

  function automatic void model_update();
    for (int i = 0; i < NREQ; i++) begin
      if (!bus.req_valid[i] || e_ready[i]) m_wait[i] = 0;
      else if (m_hold_left == 0 && m_wait[i] < STARVE_LIM) m_wait[i]++;
    end
    if (e_s2 >= 0) m_ptr = (e_s2 + 1) % NREQ;
    else if (e_s1 >= 0) m_ptr = (e_s1 + 1) % NREQ;
    if (bus.valid_flush) m_hold_left = FLUSH_HOLD;
    else if (m_hold_left > 0) m_hold_left--;
  endfunction

  // One clock cycle: drive after negedge, check combinational outputs, advance model at posedge.
  task automatic cyc(input logic flush, input logic [NREQ-1:0] valid, input logic r1,
                     input logic r2);
    @(negedge clk);
    rst             = 1'b0;
    bus.valid_flush = flush;
    bus.req_valid   = valid;
    bus.ready_1     = r1;
    bus.ready_2     = r2;
    #1;
    model_eval();
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("push_1", 32'(bus.push_1), 32'(e_s1 >= 0));
    chk("push_2", 32'(bus.push_2), 32'(e_s2 >= 0));
    chk("push_data_1", 32'(bus.push_data_1), 32'(e_d1));
    chk("push_data_2", 32'(bus.push_data_2), 32'(e_d2));
    chk("hold", 32'(bus.hold), 32'(m_hold_left > 0));
    last_ready = bus.req_ready;
    last_d1    = bus.push_data_1;
    last_d2    = bus.push_data_2;
    last_hold  = bus.hold;
    @(posedge clk);
    model_update();
  endtask

  // Raise reset with all requesters valid; outputs must drop without waiting for a clock.
  task automatic reset_check();
    @(negedge clk);
    rst             = 1'b1;
    bus.valid_flush = 1'b0;
    bus.req_valid   = '1;
    bus.ready_1     = 1'b1;
    bus.ready_2     = 1'b1;
    #1;
    chk("rst_push_1", 32'(bus.push_1), 32'd0);
    chk("rst_push_2", 32'(bus.push_2), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_hold", 32'(bus.hold), 32'd0);
    model_reset();
    last_ready = '0;
  endtask

  logic [NREQ-1:0] v;
  logic            r1, r2, fl;

  initial begin
    bus.valid_flush = 1'b0;
    bus.req_valid   = '0;
    bus.ready_1     = 1'b0;
    bus.ready_2     = 1'b0;
    for (int i = 0; i < NREQ; i++) bus.req_data[i] = DW'(16'hA000 + i);
    model_reset();
    reset_check();

    // Round-robin rotation with both slots free.
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("rr_c1_grant", 32'(last_ready), 32'h3);
    chk("rr_c1_data1", 32'(last_d1), 32'hA000);
    chk("rr_c1_data2", 32'(last_d2), 32'hA001);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("rr_c2_grant", 32'(last_ready), 32'hC);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("rr_c3_grant", 32'(last_ready), 32'h3);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("rr_c4_grant", 32'(last_ready), 32'hC);

    // Single free slot starting from pointer 0.
    cyc(1'b0, 4'b0110, 1'b1, 1'b0);
    chk("single_c1_grant", 32'(last_ready), 32'h2);
    cyc(1'b0, 4'b0110, 1'b1, 1'b0);
    chk("single_c2_grant", 32'(last_ready), 32'h4);

    // FIFO full leaves the pointer where it was (3).
    cyc(1'b0, 4'b1111, 1'b0, 1'b1);
    chk("full_grant", 32'(last_ready), 32'h0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("full_after_grant", 32'(last_ready), 32'h9);

    // Flush window.
    cyc(1'b1, 4'b1111, 1'b1, 1'b1);
    chk("flush_t_grant", 32'(last_ready), 32'h0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("flush_t1_hold", 32'(last_hold), 32'h1);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("flush_t2_grant", 32'(last_ready), 32'h0);
    chk("flush_t2_hold", 32'(last_hold), 32'h1);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("flush_t3_grant", 32'(last_ready), 32'h6);
    chk("flush_t3_hold", 32'(last_hold), 32'h0);

    // Second flush during hold extends the block by one cycle.
    cyc(1'b1, 4'b1111, 1'b1, 1'b1);
    cyc(1'b1, 4'b1111, 1'b1, 1'b1);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("reflush_t3_grant", 32'(last_ready), 32'h0);
    chk("reflush_t3_hold", 32'(last_hold), 32'h1);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("reflush_t4_grant", 32'(last_ready), 32'h9);

`ifdef STARVE_BOOST_EN
    // Requester 3 waits two RUN cycles, then beats the rr order for slot 1.
    reset_check();
    cyc(1'b0, 4'b1000, 1'b0, 1'b0);
    cyc(1'b0, 4'b1000, 1'b0, 1'b0);
    cyc(1'b0, 4'b1111, 1'b1, 1'b1);
    chk("starve_grant", 32'(last_ready), 32'h9);
    chk("starve_data1", 32'(last_d1), 32'hA003);
    chk("starve_data2", 32'(last_d2), 32'hA000);
`endif

    // Random traffic; valid/data stay stable until granted.
    v          = '0;
    last_ready = '0;
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        reset_check();
        cyc(1'b0, 4'b1111, 1'b1, 1'b1);
        chk("midrst_ptr_grant", 32'(last_ready), 32'h3);
        v = 4'b1111;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!v[i] || last_ready[i]) begin
          v[i]            = 1'($urandom_range(0, 1));
          bus.req_data[i] = DW'($urandom);
        end
      end
      r1 = ($urandom_range(0, 3) != 0);
      r2 = r1 && ($urandom_range(0, 1) == 1);
      fl = ($urandom_range(0, 15) == 0);
      cyc(fl, v, r1, r2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
